// File: rtl/gpia_pkg.sv
// Shared constants for the GPIA input port: register addresses and edge polarity codes.
package gpia_pkg;

    localparam logic [1:0] ADR_PORT   = 2'd0;
    localparam logic [1:0] ADR_STATUS = 2'd1;
    localparam logic [1:0] ADR_MASK   = 2'd2;
    localparam logic [1:0] ADR_POL    = 2'd3;

    localparam logic POL_FALL = 1'b0;
    localparam logic POL_RISE = 1'b1;

endpackage

// File: rtl/gpia_sync.sv
// WIDTH x STAGES flop synchroniser for asynchronous pin inputs; q is the last stage.
module gpia_sync #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/gpia_port_in.sv
// GPIA input port: synchronised pins, per-bit edge capture into W1C status,
// maskable interrupt and a four-register bus interface.
module gpia_port_in
    import gpia_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] inp_i,
    input  logic [WIDTH-1:0] out_i,
    input  logic [WIDTH-1:0] ddr_i,
    input  logic             stb_i,
    input  logic             we_i,
    input  logic [1:0]       adr_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic [WIDTH-1:0] dat_o,
    output logic             ack_o,
    output logic             irq_o
);

    localparam int unsigned    CW      = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0]  ARM_MAX = CW'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_lvl;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] status;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] pol;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] port_rd;
    logic [WIDTH-1:0] rd_data;
    logic [CW-1:0]    arm_cnt;
    logic             armed;
    logic             bus_go;
    logic             wr_en;

    gpia_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk_i),
        .rst (rst_i),
        .d   (inp_i),
        .q   (sync_lvl)
    );

    // Edges are ignored until the chain and prev have been refilled after reset.
    assign armed  = (arm_cnt == ARM_MAX);
    assign bus_go = stb_i & ~ack_o;
    assign wr_en  = bus_go & we_i;

    always_comb begin
        ev      = {WIDTH{armed}} & ~ddr_i &
                  ((pol & sync_lvl & ~prev) | (~pol & ~sync_lvl & prev));
        clr     = (wr_en && adr_i == ADR_STATUS) ? dat_i : '0;
        port_rd = (ddr_i & out_i) | (~ddr_i & sync_lvl);
        rd_data = '0;
        case (adr_i)
            ADR_PORT:   rd_data = port_rd;
            ADR_STATUS: rd_data = status;
            ADR_MASK:   rd_data = mask;
            ADR_POL:    rd_data = pol;
            default:    rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev    <= '0;
            status  <= '0;
            mask    <= '0;
            pol     <= '0;
            arm_cnt <= '0;
            dat_o   <= '0;
            ack_o   <= 1'b0;
            irq_o   <= 1'b0;
        end else begin
            prev <= sync_lvl;
            if (!armed) begin
                arm_cnt <= arm_cnt + CW'(1);
            end
            // OR-ing ev after the clear lets a same-cycle edge survive a W1C write.
            status <= (status & ~clr) | ev;
            if (wr_en && adr_i == ADR_MASK) begin
                mask <= dat_i;
            end
            if (wr_en && adr_i == ADR_POL) begin
                pol <= dat_i;
            end
            ack_o <= bus_go;
            if (bus_go) begin
                dat_o <= rd_data;
            end
            irq_o <= |(status & mask);
        end
    end

endmodule

// File: tb/tb_gpia_port_in.sv
// Scoreboard bench for gpia_port_in (WIDTH=8, SYNC_STAGES=2): directed vectors,
// expectations queued by the stimulus and checked by an independent monitor.
module tb_gpia_port_in;
    import gpia_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] inp, out_v, ddr, dat_wr;
    logic       stb, we;
    logic [1:0] adr;
    logic [7:0] dat_o;
    logic       ack_o, irq_o;

    typedef struct {
        bit         chk;
        logic [7:0] exp;
        string      name;
    } bus_t;

    // sel: 0 = irq_o, 1 = ack_o, 2 = dat_o; checked just after the next rising edge.
    typedef struct {
        int         sel;
        logic [7:0] exp;
        string      name;
    } now_t;

    bus_t bus_q[$];
    now_t now_q[$];
    int   errors = 0;
    int   checks = 0;
    int   wait_cnt = 0;

    gpia_port_in #(
        .WIDTH       (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .inp_i (inp),
        .out_i (out_v),
        .ddr_i (ddr),
        .stb_i (stb),
        .we_i  (we),
        .adr_i (adr),
        .dat_i (dat_wr),
        .dat_o (dat_o),
        .ack_o (ack_o),
        .irq_o (irq_o)
    );

    always #5 clk = ~clk;

    // Monitor: the only process that compares and updates the counters.
    always @(posedge clk) begin
        now_t       n;
        bus_t       b;
        logic [7:0] act;
        #1;
        while (now_q.size() > 0) begin
            n = now_q.pop_front();
            case (n.sel)
                0:       act = {7'b0, irq_o};
                1:       act = {7'b0, ack_o};
                default: act = dat_o;
            endcase
            checks++;
            if (act !== n.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", n.name, act, n.exp);
            end
        end
        if (ack_o) begin
            wait_cnt = 0;
            checks++;
            if (bus_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: got ack with no transaction pending, expected none");
            end else begin
                b = bus_q.pop_front();
                if (b.chk && dat_o !== b.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", b.name, dat_o, b.exp);
                end
            end
        end else if (bus_q.size() > 0) begin
            wait_cnt++;
            if (wait_cnt > 8) begin
                b = bus_q.pop_front();
                checks++;
                errors++;
                $display("FAIL %s: got no ack within 8 cycles, expected ack", b.name);
                wait_cnt = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_now(input int sel, input logic [7:0] exp, input string nm);
        now_q.push_back('{sel, exp, nm});
    endtask

    // Called at a negedge; returns at the negedge after the ack edge.
    task automatic bus(input logic w, input logic [1:0] a, input logic [7:0] d,
                       input bit chk, input logic [7:0] exp, input string nm);
        if (ack_o) @(negedge clk);
        stb = 1'b1; we = w; adr = a; dat_wr = d;
        bus_q.push_back('{chk, exp, nm});
        @(negedge clk);
        stb = 1'b0; we = 1'b0;
        expect_now(1, 8'h00, {nm, "_ack_drop"});
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string nm);
        bus(1'b0, a, 8'h00, 1'b1, exp, nm);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d, input string nm);
        bus(1'b1, a, d, 1'b0, 8'h00, nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; inp = 8'hFF; out_v = 8'h00; ddr = 8'h00;
        stb = 1'b0; we = 1'b0; adr = 2'd0; dat_wr = 8'h00;

        // Reset with pins high
        tick(1);
        expect_now(0, 8'h00, "rst_irq");
        expect_now(1, 8'h00, "rst_ack");
        expect_now(2, 8'h00, "rst_dat");
        tick(1);
        rst = 1'b0;
        expect_now(2, 8'h00, "post_rst_dat");
        tick(1);
        rd(ADR_STATUS, 8'h00, "arm_status_early");
        tick(3);
        rd(ADR_STATUS, 8'h00, "arm_status");
        rd(ADR_PORT, 8'hFF, "port_after_reset");

        // Readback mux; bits 0,1 fall as inputs, bits 6,7 are outputs
        ddr = 8'hF0; out_v = 8'hA5; inp = 8'h3C;
        tick(4);
        rd(ADR_PORT, 8'hAC, "port_mux");
        rd(ADR_STATUS, 8'h03, "status_fall_01");
        wr(ADR_STATUS, 8'hFF, "clr_all");
        rd(ADR_STATUS, 8'h00, "status_cleared");

        // Rising edge on bit 0 -> status at edge 3, irq at edge 4
        wr(ADR_POL, 8'h01, "wr_pol");
        wr(ADR_MASK, 8'h01, "wr_mask");
        rd(ADR_POL, 8'h01, "rd_pol");
        tick(2);
        inp = 8'h3D;
        expect_now(0, 8'h00, "irq_edge1");
        tick(1);
        expect_now(0, 8'h00, "irq_edge2");
        tick(1);
        expect_now(0, 8'h00, "irq_edge3");
        tick(1);
        expect_now(0, 8'h01, "irq_edge4");
        tick(1);
        rd(ADR_STATUS, 8'h01, "status_rise_0");
        tick(1);
        expect_now(0, 8'h01, "irq_before_clear");
        wr(ADR_STATUS, 8'h01, "clr_bit0");
        expect_now(0, 8'h00, "irq_after_clear");
        tick(2);

        // Falling edge on bit 2 coincides with its W1C write
        inp = 8'h39;
        tick(2);
        wr(ADR_STATUS, 8'h04, "clr_race");
        rd(ADR_STATUS, 8'h04, "set_beats_clear");
        wr(ADR_STATUS, 8'h04, "clr_bit2");
        rd(ADR_STATUS, 8'h00, "status_bit2_cleared");

        // Output-configured bit toggling never sets status
        tick(1);
        ddr = 8'h02;
        for (int i = 0; i < 4; i++) begin
            inp = (i % 2 == 0) ? 8'h3B : 8'h39;
            tick(3);
            expect_now(0, 8'h00, "irq_out_bit");
        end
        tick(2);
        rd(ADR_STATUS, 8'h00, "status_out_bit");
        rd(ADR_PORT, 8'h39, "port_ddr02");

        // Mask gating on bit 4 (falling)
        wr(ADR_MASK, 8'h00, "mask_off");
        tick(1);
        inp = 8'h29;
        tick(4);
        rd(ADR_STATUS, 8'h10, "status_bit4");
        tick(1);
        expect_now(0, 8'h00, "irq_masked_a");
        tick(1);
        expect_now(0, 8'h00, "irq_masked_b");
        wr(ADR_MASK, 8'h10, "mask_on");
        expect_now(0, 8'h01, "irq_unmasked");
        tick(1);
        rd(ADR_MASK, 8'h10, "rd_mask");

        for (int i = 0; i < 20 && (bus_q.size() > 0 || now_q.size() > 0); i++) tick(1);
        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpia_port_in.md
Name: gpia_port_in

Overview:
- Parametrised GPIA input port. Replaces the single-bit input mux with a WIDTH-bit port.
- Each input is synchronised, then edges are detected per bit. Edges latch into a write-1-to-clear status register, which raises a maskable interrupt.
- Readback is per bit: the last written output value where DDR marks the bit as an output, otherwise the synchronised pin.
- Sits between the GPIA pins/output latch and the processing element's Wishbone-style I/O bus.

Parameters:
- WIDTH, 16, number of I/O bits in the port (1..32).
- SYNC_STAGES, 2, synchroniser flops per input bit (2..4).

Ports:
- clk_i  in  1  system clock; all state changes on its rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- inp_i  in  WIDTH  raw external pin levels, asynchronous to clk_i.
- out_i  in  WIDTH  current output latch value.
- ddr_i  in  WIDTH  direction per bit; 1 = output, 0 = input.
- stb_i  in  1  bus cycle strobe.
- we_i  in  1  write enable, qualified by stb_i.
- adr_i  in  2  register select.
- dat_i  in  WIDTH  write data.
- dat_o  out  WIDTH  registered read data.
- ack_o  out  1  bus acknowledge.
- irq_o  out  1  registered interrupt request.

Behaviour:
- Reset (rst_i high, asynchronous) clears: synchroniser chain, prev register, status, mask, polarity, arm counter, dat_o, ack_o, irq_o.
- Synchroniser: sync[0] <= inp_i; sync[i] <= sync[i-1]. The synchronised level S is the last stage.
- Previous-sample register: prev <= S every cycle.
- Arm counter:
  - 0 at reset; counts up to SYNC_STAGES+1, then saturates.
  - Signal armed = (count == SYNC_STAGES+1).
  - Edge detection is suppressed while not armed, so pins high at reset do not give spurious edges.
- Edge event per bit: ev = armed & ~ddr_i & (pol ? (S & ~prev) : (~S & prev)).
  - pol = 1 selects rising edges; pol = 0 selects falling edges.
  - Bits configured as outputs never set status.
- Register map:
  - adr 0, PORT: read-only; per bit ddr_i ? out_i : S. Writes are ignored.
  - adr 1, STATUS: read returns status. Write-1-to-clear: status <= (status & ~clr) | ev, where clr = dat_i on a write, else 0.
  - adr 2, MASK: read/write; 1 enables the bit's interrupt.
  - adr 3, POL: read/write edge polarity per bit.
- Simultaneous clear and new edge on the same bit in the same cycle: set wins, and the bit stays 1.
- Bus handshake:
  - ack_o <= stb_i & ~ack_o, i.e. one-cycle pulse on the edge after stb_i is sampled.
  - A held stb_i yields ack on alternate cycles.
  - Register writes and the dat_o load happen only on the edge where ack_o goes high, i.e. stb_i & ~ack_o.
  - dat_o holds its value otherwise.
- Latency:
  - Pin change stable before edge 1 appears in S after edge SYNC_STAGES.
  - The status bit sets at edge SYNC_STAGES+1.
  - irq_o asserts at edge SYNC_STAGES+2.
- irq_o <= |(status & mask). It deasserts one cycle after the last enabled status bit clears or its mask bit clears.
- A DDR change mid-operation takes effect combinationally on ev and on the PORT read mux. Status bits that are already latched are kept.
- Reset asserted mid-bus-cycle: ack_o drops immediately. A write in progress is discarded.

Decomposition:
- Shared package gpia_pkg holds:
  - register address constants: ADR_PORT=0, ADR_STATUS=1, ADR_MASK=2, ADR_POL=3;
  - POL_FALL=0 and POL_RISE=1.
- One natural sub-module: gpia_sync, a parametrised WIDTH x SYNC_STAGES synchroniser with asynchronous reset. It is instantiated once.

Test Plan:
- Reset: WIDTH=8, SYNC_STAGES=2, inp_i=8'hFF held through reset.
  - All outputs are 0 during reset.
  - After release, STATUS stays 8'h00 (arm suppression).
  - PORT reads 8'hFF once synchronised.
- Readback mux: ddr_i=8'hF0, out_i=8'hA5, inp_i=8'h3C -> PORT read returns 8'hAC, with ack_o pulsing one cycle after stb_i.
- Rising edge and interrupt: POL=8'h01, MASK=8'h01, inp_i[0] 0->1 just before edge 1.
  - STATUS=8'h01 at edge 3.
  - irq_o=1 at edge 4.
  - Write 8'h01 to STATUS -> irq_o=0 on the following edge.
- Set beats clear: a falling edge on bit 2 (POL=0) lands in the same cycle as a STATUS write of 8'h04 -> STATUS reads 8'h04 afterwards.
- Output bit ignored: ddr_i=8'h02, toggle inp_i[1] repeatedly -> STATUS[1] stays 0 and irq_o stays 0.
- Mask gating:
  - STATUS=8'h10, MASK=8'h00 -> irq_o stays 0.
  - Write MASK=8'h10 -> irq_o=1 one edge after the write's ack.
